// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between
// instruction fetch (IF) and the load/store unit (LS).
module mem_port_arbiter #(
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [DATA_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              stall_if,
    output logic              stall_ls
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_LS = 1'b1;
    localparam logic [3:0] LAT    = 4'(MEM_LAT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_last_gnt;
    logic                r_owner;
    logic                r_we;
    logic                r_if_rvalid;
    logic                r_ls_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_ls_rdata;
    logic                w_grant;
    logic                w_winner;
    logic                w_capture;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_winner    = r_owner;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so every output reads 0 while reset is held.
                if (!reset && (if_req || ls_req)) begin
                    w_grant     = 1'b1;
                    w_winner    = (if_req && ls_req) ? ~r_last_gnt : ls_req;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 4'd1;
                end
            end
            S_WAIT: begin
                if (r_cnt == LAT) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if_gnt    = w_grant && (w_winner == OWN_IF);
        ls_gnt    = w_grant && (w_winner == OWN_LS);
        mem_en    = w_grant;
        mem_we    = ls_gnt && ls_we;
        owner     = w_grant ? w_winner : r_owner;
        mem_addr  = !w_grant ? '0 : ((w_winner == OWN_LS) ? ls_addr : if_addr);
        mem_wdata = ls_gnt ? ls_wdata : '0;
        stall_if  = !reset && if_req && !if_gnt;
        stall_ls  = !reset && ls_req && !ls_gnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_gnt  <= OWN_LS;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_if_rvalid <= w_capture && (r_owner == OWN_IF);
            r_ls_rvalid <= w_capture && (r_owner == OWN_LS);
            if (w_grant) begin
                r_owner    <= w_winner;
                r_last_gnt <= w_winner;
                r_we       <= ls_gnt && ls_we;
            end
            if (w_capture) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= mem_rdata;
                end else begin
                    r_ls_rdata <= r_we ? '0 : mem_rdata;
                end
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=2 instance with a response scoreboard,
// plus a MEM_LAT=1 instance for the single-cycle WAIT case.
module tb_mem_port_arbiter;

    typedef struct {
        logic        own;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q[$];

    // Memory contents: address XOR constant, so 0x100 reads back 0xDEAD.
    function automatic logic [63:0] f(input logic [63:0] a);
        return a ^ 64'hDFAD;
    endfunction

    // MEM_LAT = 2 instance
    logic        if_req, if_gnt, if_rvalid, ls_req, ls_we, ls_gnt, ls_rvalid;
    logic        mem_en, mem_we, owner, stall_if, stall_ls;
    logic [63:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [63:0] pipe_a [0:1];

    mem_port_arbiter #(.DATA_W(64), .MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .stall_if(stall_if), .stall_ls(stall_ls)
    );

    always @(posedge clk) begin
        pipe_a[0] <= mem_en ? f(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        pipe_a[1] <= pipe_a[0];
    end
    assign mem_rdata = pipe_a[1];

    // MEM_LAT = 1 instance
    logic        b_if_req, b_if_gnt, b_if_rvalid, b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid;
    logic        b_mem_en, b_mem_we, b_owner, b_stall_if, b_stall_ls;
    logic [63:0] b_if_addr, b_if_rdata, b_ls_addr, b_ls_wdata, b_ls_rdata;
    logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.DATA_W(64), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
        .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .owner(b_owner), .stall_if(b_stall_if), .stall_ls(b_stall_ls)
    );

    always @(posedge clk) begin
        b_mem_rdata <= b_mem_en ? f(b_mem_addr) : 64'hBAD1_BAD1_BAD1_BAD1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    // Scoreboard consumer: every rvalid must match the oldest expected response.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] got;
        #2;
        if (if_rvalid || ls_rvalid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: if_rvalid=%b ls_rvalid=%b cycle=%0d, required none",
                         if_rvalid, ls_rvalid, cyc);
            end else begin
                e = q.pop_front();
                if ({ls_rvalid, if_rvalid} !== (e.own ? 2'b10 : 2'b01) || e.due != cyc) begin
                    n_fail++;
                    $display("FAIL rvalid_timing: ls/if=%b%b cycle=%0d, required owner=%0d cycle=%0d",
                             ls_rvalid, if_rvalid, cyc, e.own, e.due);
                end
                got = e.own ? ls_rdata : if_rdata;
                n_checks++;
                if (got !== e.data) begin
                    n_fail++;
                    $display("FAIL rdata: got %h, required %h (owner=%0d)", got, e.data, e.own);
                end
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rvalid_missing: none at cycle %0d, required owner=%0d", cyc, e.own);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; if_req = 1'b1; ls_req = 1'b1; if_addr = 64'hFFFF; ls_addr = 64'hEEEE;
        #1;
        n_checks++;
        if ({if_gnt, ls_gnt, mem_en, mem_we, owner, stall_if, stall_ls, if_rvalid, ls_rvalid} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt/en/we/own/stall/rvalid=%b, required 0",
                     {if_gnt, ls_gnt, mem_en, mem_we, owner, stall_if, stall_ls, if_rvalid, ls_rvalid});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== 256'b0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h ls_rdata=%h, required 0",
                     mem_addr, mem_wdata, if_rdata, ls_rdata);
        end
        @(negedge clk);
        reset = 1'b0; if_addr = 64'h700;
        #1;
        n_checks++;
        if ({if_gnt, ls_gnt, stall_ls} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_first_tie: if_gnt/ls_gnt/stall_ls=%b, required 101", {if_gnt, ls_gnt, stall_ls});
        end
        q.push_back('{1'b0, f(64'h700), cyc + 3});
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h100;
        #1;
        n_checks++;
        if ({if_gnt, mem_en, mem_we, owner} !== 4'b1100 || mem_addr !== 64'h100 || mem_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL if_read_grant: gnt/en/we/own=%b addr=%h wdata=%h, required 1100 addr=100 wdata=0",
                     {if_gnt, mem_en, mem_we, owner}, mem_addr, mem_wdata);
        end
        q.push_back('{1'b0, 64'hDEAD, cyc + 3});
        @(negedge clk);
        if_req = 1'b0;
        #1;
        n_checks++;
        if ({if_gnt, mem_en, owner} !== 3'b000) begin
            n_fail++;
            $display("FAIL if_read_wait: gnt/en/own=%b, required 000", {if_gnt, mem_en, owner});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ls_write();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h200; ls_wdata = 64'h55;
        #1;
        n_checks++;
        if ({ls_gnt, if_gnt, mem_en, mem_we, owner, stall_ls} !== 6'b101110 ||
            mem_addr !== 64'h200 || mem_wdata !== 64'h55) begin
            n_fail++;
            $display("FAIL ls_write_grant: gnt_ls/gnt_if/en/we/own/stall=%b addr=%h wdata=%h, required 101110 200 55",
                     {ls_gnt, if_gnt, mem_en, mem_we, owner, stall_ls}, mem_addr, mem_wdata);
        end
        q.push_back('{1'b1, 64'h0, cyc + 3});
        @(negedge clk);
        ls_req = 1'b0; ls_we = 1'b0; ls_wdata = 64'h0;
        #1;
        n_checks++;
        if ({owner, mem_en, mem_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL ls_write_hold: own/en/we=%b, required 100", {owner, mem_en, mem_we});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_contention();
        logic [63:0] ia, la;
        logic        exp_if, exp_ls, bump_if, bump_ls;
        ia = 64'h1000; la = 64'h2000; bump_if = 1'b0; bump_ls = 1'b0;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            if (bump_if) ia = ia + 64'h8;
            if (bump_ls) la = la + 64'h8;
            if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; if_addr = ia; ls_addr = la;
            #1;
            exp_if = (r % 3 == 0) && ((r / 3) % 2 == 0);
            exp_ls = (r % 3 == 0) && ((r / 3) % 2 == 1);
            n_checks++;
            if ({if_gnt, ls_gnt, mem_en, stall_if, stall_ls} !== {exp_if, exp_ls, exp_if | exp_ls, !exp_if, !exp_ls}) begin
                n_fail++;
                $display("FAIL contention_r%0d: gnt_if/gnt_ls/en/stall_if/stall_ls=%b, required %b", r,
                         {if_gnt, ls_gnt, mem_en, stall_if, stall_ls},
                         {exp_if, exp_ls, exp_if | exp_ls, !exp_if, !exp_ls});
            end
            if (exp_if || exp_ls) begin
                n_checks++;
                if (owner !== exp_ls || mem_addr !== (exp_ls ? la : ia)) begin
                    n_fail++;
                    $display("FAIL contention_mux_r%0d: owner=%b addr=%h, required %b %h", r,
                             owner, mem_addr, exp_ls, exp_ls ? la : ia);
                end
                q.push_back('{exp_ls, f(exp_ls ? la : ia), cyc + 3});
            end
            bump_if = exp_if;
            bump_ls = exp_ls;
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_withdraw();
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h3000;
        #1;
        q.push_back('{1'b0, f(64'h3000), cyc + 3});
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b1; ls_addr = 64'h4000;
        #1;
        n_checks++;
        if ({ls_gnt, stall_ls, mem_en} !== 3'b010) begin
            n_fail++;
            $display("FAIL withdraw_wait: gnt/stall/en=%b, required 010", {ls_gnt, stall_ls, mem_en});
        end
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        n_checks++;
        if ({ls_gnt, stall_ls, mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL withdraw_drop: gnt/stall/en=%b, required 000", {ls_gnt, stall_ls, mem_en});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({ls_gnt, if_gnt, mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL withdraw_idle: gnt_ls/gnt_if/en=%b, required 000", {ls_gnt, if_gnt, mem_en});
        end
        @(negedge clk);
        ls_req = 1'b1; ls_addr = 64'h4100;
        #1;
        n_checks++;
        if (ls_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_newreq: ls_gnt=%b, required 1", ls_gnt);
        end
        q.push_back('{1'b1, f(64'h4100), cyc + 3});
        @(negedge clk);
        ls_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h5000;
        #1;
        n_checks++;
        if (if_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_grant: if_gnt=%b, required 1", if_gnt);
        end
        @(negedge clk);
        reset = 1'b1; if_req = 1'b1; ls_req = 1'b1;
        #1;
        n_checks++;
        if ({if_gnt, ls_gnt, mem_en, owner, stall_if, stall_ls, if_rvalid, ls_rvalid} !== 8'b0 ||
            mem_addr !== 64'h0 || if_rdata !== 64'h0 || ls_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL midflight_reset: ctrl=%b addr=%h if_rdata=%h ls_rdata=%h, required all 0",
                     {if_gnt, ls_gnt, mem_en, owner, stall_if, stall_ls, if_rvalid, ls_rvalid},
                     mem_addr, if_rdata, ls_rdata);
        end
        @(negedge clk);
        reset = 1'b0; if_addr = 64'h5100; ls_addr = 64'h6100;
        #1;
        n_checks++;
        if ({if_gnt, ls_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL midflight_tie: if_gnt/ls_gnt=%b, required 10", {if_gnt, ls_gnt});
        end
        q.push_back('{1'b0, f(64'h5100), cyc + 3});
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lat1();
        @(negedge clk);
        b_if_req = 1'b1; b_if_addr = 64'h40; b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_addr = 64'h80;
        #1;
        n_checks++;
        if ({b_if_gnt, b_ls_gnt, b_stall_ls} !== 3'b101) begin
            n_fail++;
            $display("FAIL lat1_c0: gnt_if/gnt_ls/stall_ls=%b, required 101", {b_if_gnt, b_ls_gnt, b_stall_ls});
        end
        @(negedge clk);
        b_if_req = 1'b0;
        #1;
        n_checks++;
        if ({b_ls_gnt, b_stall_ls, b_if_rvalid} !== 3'b010) begin
            n_fail++;
            $display("FAIL lat1_c1: gnt_ls/stall_ls/if_rvalid=%b, required 010", {b_ls_gnt, b_stall_ls, b_if_rvalid});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({b_ls_gnt, b_if_rvalid} !== 2'b11 || b_if_rdata !== f(64'h40)) begin
            n_fail++;
            $display("FAIL lat1_c2: gnt_ls/if_rvalid=%b if_rdata=%h, required 11 %h",
                     {b_ls_gnt, b_if_rvalid}, b_if_rdata, f(64'h40));
        end
        @(negedge clk);
        b_ls_req = 1'b0;
        #1;
        n_checks++;
        if ({b_if_rvalid, b_ls_rvalid, b_mem_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL lat1_c3: if_rvalid/ls_rvalid/en=%b, required 000", {b_if_rvalid, b_ls_rvalid, b_mem_en});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (b_ls_rvalid !== 1'b1 || b_ls_rdata !== f(64'h80)) begin
            n_fail++;
            $display("FAIL lat1_c4: ls_rvalid=%b ls_rdata=%h, required 1 %h", b_ls_rvalid, b_ls_rdata, f(64'h80));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0; b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_addr = '0; b_ls_wdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_if_read();
        test_ls_write();
        test_contention();
        test_withdraw();
        test_reset_midflight();
        test_lat1();
        repeat (2) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
